// File: rtl/platform_pio_pkg.sv
// platform_pio_pkg: register map and edge-type encodings shared by the input PIO.
package platform_pio_pkg;
  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_RAW      = 2'd1;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;
endpackage

// File: rtl/pio_debounce_bit.sv
// pio_debounce_bit: two-flop synchronizer plus hold-time debounce filter for one input,
// flagging the cycle on which the filtered level changes in the selected direction.
module pio_debounce_bit
  import platform_pio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = EDGE_RISE,
  parameter bit RESET_VALUE     = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic raw,
  output logic level,
  output logic hit
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic sync1;
  logic commit;
  logic [CW-1:0] cnt, cnt_next;
  always_comb begin
    commit   = (raw != level) && (cnt == LAST);
    cnt_next = (raw == level || commit) ? '0 : cnt + 1'b1;
    hit      = commit && (EDGE_TYPE == EDGE_ANY || (EDGE_TYPE == EDGE_FALL ? !raw : raw));
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sync1 <= RESET_VALUE;
      raw   <= RESET_VALUE;
      level <= RESET_VALUE;
      cnt   <= '0;
    end else begin
      sync1 <= pin;
      raw   <= sync1;
      cnt   <= cnt_next;
      if (commit) level <= raw;
    end
endmodule

// File: rtl/platform_pio_input_debounced.sv
// platform_pio_input_debounced: Avalon-MM input PIO with per-bit debounce, edge capture
// and a maskable level interrupt.
module platform_pio_input_debounced
  import platform_pio_pkg::*;
#(
  parameter int               WIDTH           = 8,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter int               EDGE_TYPE       = EDGE_RISE,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);
  logic [WIDTH-1:0] raw, stable, hit, irq_mask, edge_capture, clr;
  logic wr;
  logic unused_wd;
  assign unused_wd = ^writedata;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pio_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .EDGE_TYPE      (EDGE_TYPE),
      .RESET_VALUE    (RESET_VALUE[i])
    ) u_bit (
      .clk    (clk),
      .reset_n(reset_n),
      .pin    (in_port[i]),
      .raw    (raw[i]),
      .level  (stable[i]),
      .hit    (hit[i])
    );
  end
  always_comb begin
    wr       = chipselect && !write_n;
    clr      = (wr && address == ADDR_EDGE_CAP) ? writedata[WIDTH-1:0] : '0;
    readdata = address == ADDR_DATA     ? 32'(stable)   :
               address == ADDR_RAW      ? 32'(raw)      :
               address == ADDR_IRQ_MASK ? 32'(irq_mask) : 32'(edge_capture);
    irq      = |(edge_capture & irq_mask);
  end
  // a new edge outranks a same-cycle write-1-to-clear
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      irq_mask     <= '0;
      edge_capture <= '0;
    end else begin
      if (wr && address == ADDR_IRQ_MASK) irq_mask <= writedata[WIDTH-1:0];
      edge_capture <= (edge_capture & ~clr) | hit;
    end
endmodule

// File: doc/platform_pio_input_debounced.md
Name: platform_pio_input_debounced

Overview:
- Avalon-MM slave input PIO for push-buttons and switches.
- Each of WIDTH external inputs passes through a two-flop synchronizer and a per-bit debounce filter before it is visible to the CPU.
- Debounced edges are latched in an edge-capture register, and a maskable level interrupt is raised to the processor.
- It is the read-side counterpart of the platform's 8-bit output PIO and sits on the same system interconnect, with the same register timing.

Parameters:
- WIDTH, 8: number of input bits, 1..32.
- DEBOUNCE_CYCLES, 50000: consecutive clk cycles a changed synchronized level must hold before it is accepted; minimum 2.
- EDGE_TYPE, 0: edge that sets a capture bit. 0 = rising, 1 = falling, 2 = any.
- RESET_VALUE, 0: WIDTH-bit idle level of the inputs. The synchronizer and debounced registers reset to this value, so reset produces no spurious edge.

Ports:
- clk  input  1  system clock; the block uses this one clock only.
- reset_n  input  1  asynchronous, active-low reset.
- address  input  2  register select.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe.
- writedata  input  32  write data.
- readdata  output  32  read data; zero wait states, read latency 0.
- in_port  input  WIDTH  raw asynchronous external inputs.
- irq  output  1  level interrupt to the processor.

Behaviour:
- Reset: all of the following take their reset value immediately when reset_n is low, regardless of clk.
  - sync1, sync2, stable = RESET_VALUE.
  - All debounce counters, irq_mask and edge_capture = 0.
  - irq = 0.
  - readdata = RESET_VALUE zero-extended, since address 0 selects stable.
- Synchronizer: sync1 <= in_port; sync2 <= sync1.
- Debounce, per bit:
  - If sync2 == stable, cnt <= 0.
  - Otherwise, if cnt == DEBOUNCE_CYCLES-1: stable <= sync2 and cnt <= 0.
  - Otherwise cnt <= cnt+1.
  - cnt width is clog2(DEBOUNCE_CYCLES); the counter saturates via the compare and never wraps.
- Latency: a level that is constant at in_port from sampling edge E appears in stable after edge E+DEBOUNCE_CYCLES+1. Example: DEBOUNCE_CYCLES=4 gives the update at edge E+5.
- Glitch rejection: a change that holds at sync2 for fewer than DEBOUNCE_CYCLES cycles resets cnt and never reaches stable.
- Edge event, per bit, evaluated on the cycle stable changes:
  - EDGE_TYPE 0: rise = stable_next & ~stable.
  - EDGE_TYPE 1: fall = ~stable_next & stable.
  - EDGE_TYPE 2: either.
- Register map (address is a word index):
  - 0 DATA, read-only: stable, zero-extended. Writes are ignored.
  - 1 RAW, read-only: sync2, zero-extended. Diagnostic only. Writes are ignored.
  - 2 IRQ_MASK, read/write: on a write, irq_mask <= writedata[WIDTH-1:0].
  - 3 EDGE_CAPTURE, read / write-1-to-clear: a write clears each bit whose writedata bit is 1.
- Write qualifier: a write takes effect when chipselect && ~write_n at the rising clk edge.
- readdata: combinational mux of address. It does not depend on chipselect. Bits above WIDTH read 0.
- Set/clear collision: if an edge event and a W1C on the same bit occur in the same cycle, set wins and the bit stays 1.
- irq = |(edge_capture & irq_mask). It is combinational from flops and therefore glitch-free.
  - Changing irq_mask affects irq on the cycle after the write.
  - Clearing edge_capture deasserts irq on the cycle after the write.
- Reset mid-debounce: counters clear and stable returns to RESET_VALUE. No edge is captured on reset deassertion.

Decomposition:
- Package platform_pio_pkg holds:
  - Register address constants ADDR_DATA=0, ADDR_RAW=1, ADDR_IRQ_MASK=2, ADDR_EDGE_CAP=3.
  - EDGE_TYPE encodings EDGE_RISE=0, EDGE_FALL=1, EDGE_ANY=2.
- Sub-module pio_debounce_bit contains the synchronizer, the counter and the stable flop, with an edge-event output. The top level instantiates it WIDTH times in a generate loop.
- Register file, readdata mux and irq logic stay in the top level.

Test Plan (WIDTH=8, DEBOUNCE_CYCLES=4, EDGE_TYPE=0, RESET_VALUE=0):
1. Assert reset_n=0 mid-cycle with in_port=8'hFF -> immediately readdata=0 at addr 0, irq=0, edge_capture=0. After release, DATA reads 8'hFF 6 edges later and edge_capture reads 8'hFF.
2. in_port[0] 0->1, held -> DATA bit 0 = 1 exactly after edge E+5, not at E+4. EDGE_CAPTURE=8'h01. irq stays 0 because mask=0.
3. in_port[1] pulses high for 3 cycles -> RAW shows the pulse. DATA and EDGE_CAPTURE are unchanged.
4. Write IRQ_MASK=8'h01 with capture bit 0 set -> irq=1 the next cycle. Write EDGE_CAPTURE=8'h01 -> bit clears and irq=0 the next cycle. Write 8'h00 -> no change.
5. W1C of bit 2 in the same cycle that a rising edge commits on bit 2 -> EDGE_CAPTURE bit 2 remains 1.
6. Write 8'hAA to DATA and RAW, and write to IRQ_MASK with chipselect=0 -> no register changes. Readback of addr 2 = previous mask.
